mux_832: RTL and testbench
==========================

MUX_832 -- requirements
Module: mux_832

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. The clock port SHALL be named CLK and the reset port RSTN.
REQ-002 Parameter: WIDTH, default 32, data width of every data input and output. Only the value 32 is required to be verified.
REQ-003 Port: CLK, input, 1, rising-edge clock for the registered output path.
REQ-004 Port: RSTN, input, 1, asynchronous active-low reset of the registered output path.
REQ-005 Port: SEL, input, 3, select code choosing one of eight data inputs.
REQ-006 Ports: D0, D1, D2, D3, D4, D5, D6, D7, each input, WIDTH, candidate data words; Dn is chosen when SEL equals n.
REQ-007 Port: EN, input, 1, load enable for the registered output.
REQ-008 Port: Y, output, WIDTH, combinational selected word.
REQ-009 Port: YQ, output, WIDTH, registered selected word.
REQ-010 Port order SHALL be CLK, RSTN, SEL, D0..D7, EN, Y, YQ.

Function
REQ-011 Y SHALL equal D[SEL] combinationally for all eight SEL codes: 000->D0, 001->D1, and so on through 111->D7.
REQ-012 Y SHALL have zero cycle latency and SHALL NOT depend on CLK, RSTN or EN.
REQ-013 Y SHALL be built as a one-hot decode of SEL, with each Dn masked by its replicated decode bit and the eight masked words ORed together.
REQ-014 Exactly one decode term SHALL be active for any known SEL value.
REQ-015 Y SHALL never be an OR of two or more inputs.
REQ-016 Any change on SEL or on the selected Dn SHALL propagate to Y in the same delta or evaluation cycle.
REQ-017 Changes on unselected inputs SHALL NOT affect Y.
REQ-018 On each rising edge of CLK with RSTN high and EN high, YQ SHALL load the value of Y present before the edge.
REQ-019 On a rising edge with EN low, YQ SHALL hold its value.
REQ-020 YQ latency SHALL be exactly one CLK cycle from the SEL/Dn inputs.
REQ-021 Boundary: SEL=000 and SEL=111 SHALL select D0 and D7 respectively, with no wrap-around or off-by-one error.
REQ-022 Boundary: all-ones and all-zeros data words SHALL pass through unmodified on all 32 bits.
REQ-023 If SEL changes in the same cycle that EN is high, YQ SHALL capture the word selected by the new SEL value settled before the edge.
REQ-024 The block SHALL be width-preserving: no sign extension, truncation or arithmetic is performed.

Reset
REQ-025 RSTN low SHALL force YQ to 0 immediately, without waiting for a CLK edge.
REQ-026 YQ SHALL remain 0 while RSTN is low, regardless of CLK and EN.
REQ-027 Y SHALL remain fully functional during reset.
REQ-028 Reset deassertion SHALL be synchronized by the integrator. After RSTN rises, the first rising edge with EN high SHALL load YQ.
REQ-029 Reset asserted mid-operation SHALL discard the held YQ value. No other state exists.

Verification
REQ-030 Scenario: D0..D7 = 0x00000000, 0x11111111, ..., 0x77777777; sweep SEL 0..7 -> Y = 0xn*nnnnnnn (D[SEL]) each step.
REQ-031 Scenario: D7 = 0xFFFFFFFF, others 0; SEL=7 -> Y=0xFFFFFFFF; SEL=6 -> Y=0x00000000.
REQ-032 Scenario: SEL=3, D3=0xDEADBEEF, EN=1, one CLK edge -> YQ=0xDEADBEEF; then D3=0x12345678, EN=0, one edge -> YQ still 0xDEADBEEF.
REQ-033 Scenario: YQ=0xDEADBEEF; drive RSTN low between clock edges -> YQ=0 immediately; Y still equals D[SEL].
REQ-034 Scenario: SEL=2, toggle D5 randomly while D2 is held -> Y unchanged and equal to D2.
REQ-035 Scenario: random SEL/Dn/EN over 1000 cycles -> Y matches the reference-model selection every cycle, and YQ matches the previous cycle's Y whenever EN was high.

Source files
------------

// File: rtl/mux_832.sv
// Purpose: 8:1 word multiplexer with a combinational output and an enable-loaded registered copy.
// Latency: Y follows SEL/Dn with zero cycles; YQ holds the selected word one CLK cycle later.
// Backpressure: none; EN low holds YQ, RSTN low clears YQ asynchronously.
module mux_832 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [2:0]       SEL,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  logic [WIDTH-1:0] D4,
  input  logic [WIDTH-1:0] D5,
  input  logic [WIDTH-1:0] D6,
  input  logic [WIDTH-1:0] D7,
  input  logic             EN,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] YQ
);

  // Candidate words gathered so the and-or tree can be written as one loop.
  logic [WIDTH-1:0] d_arr [8];
  logic [7:0]       dec;
  logic [WIDTH-1:0] y_acc;

  assign d_arr[0] = D0;
  assign d_arr[1] = D1;
  assign d_arr[2] = D2;
  assign d_arr[3] = D3;
  assign d_arr[4] = D4;
  assign d_arr[5] = D5;
  assign d_arr[6] = D6;
  assign d_arr[7] = D7;

  // One-hot decode of SEL; an unknown code selects nothing rather than ORing words together.
  always_comb begin
    dec = 8'b0000_0000;
    case (SEL)
      3'd0:    dec = 8'b0000_0001;
      3'd1:    dec = 8'b0000_0010;
      3'd2:    dec = 8'b0000_0100;
      3'd3:    dec = 8'b0000_1000;
      3'd4:    dec = 8'b0001_0000;
      3'd5:    dec = 8'b0010_0000;
      3'd6:    dec = 8'b0100_0000;
      3'd7:    dec = 8'b1000_0000;
      default: dec = 8'b0000_0000;
    endcase
  end

  // Mask each word with its replicated decode bit and OR the eight masked words.
  always_comb begin
    y_acc = '0;
    for (int i = 0; i < 8; i++) begin
      y_acc = y_acc | (d_arr[i] & {WIDTH{dec[i]}});
    end
  end

  assign Y = y_acc;

  // Registered copy: cleared by reset, loaded from Y when EN is high, otherwise held.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      YQ <= '0;
    end else if (EN) begin
      YQ <= y_acc;
    end
  end

endmodule

// File: tb/tb_mux_832.sv
module tb_mux_832;

  logic        clk;
  logic        rstn;
  logic [2:0]  sel;
  logic [31:0] d [8];
  logic        en;
  logic [31:0] y;
  logic [31:0] yq;

  int total;
  int bad;

  // Scoreboard of expected YQ values, one entry per clock edge.
  logic [31:0] exp_q [$];
  logic [31:0] exp_yq;

  mux_832 #(.WIDTH(32)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .SEL  (sel),
    .D0   (d[0]),
    .D1   (d[1]),
    .D2   (d[2]),
    .D3   (d[3]),
    .D4   (d[4]),
    .D5   (d[5]),
    .D6   (d[6]),
    .D7   (d[7]),
    .EN   (en),
    .Y    (y),
    .YQ   (yq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Let combinational logic settle, then compare Y with the reference selection.
  task automatic check_y(input string tag);
    logic [31:0] ref_y;
    #1;
    ref_y = d[sel];
    chk(tag, y, ref_y);
  endtask

  // Predict YQ for the coming edge, clock it, compare, and return to the falling edge.
  task automatic clock_edge(input string tag);
    logic [31:0] e;
    if (!rstn)   exp_q.push_back(32'h0);
    else if (en) exp_q.push_back(d[sel]);
    else         exp_q.push_back(exp_yq);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, yq, 32'hx);
    end else begin
      e = exp_q.pop_front();
      exp_yq = e;
      chk(tag, yq, e);
    end
    @(negedge clk);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    exp_yq = 32'h0;
    rstn   = 1'b0;
    en     = 1'b0;
    sel    = 3'd0;
    for (int i = 0; i < 8; i++) d[i] = 32'h0;

    // Reset state and Y functional during reset.
    #2;
    chk("reset_yq", yq, 32'h0);
    d[4] = 32'hA5A5_5A5A;
    sel  = 3'd4;
    check_y("reset_y_live");
    en = 1'b1;
    clock_edge("reset_hold_en");
    rstn = 1'b1;

    // Sweep with distinct words 0x0..0x7777_7777.
    for (int i = 0; i < 8; i++) d[i] = 32'h1111_1111 * i;
    for (int s = 0; s < 8; s++) begin
      sel = s[2:0];
      check_y($sformatf("sweep_y_sel%0d", s));
    end

    // First enabled edge after reset release loads YQ; SEL change before the edge wins.
    sel = 3'd1;
    #1;
    sel = 3'd6;
    check_y("sel_change_y");
    clock_edge("sel_change_yq");

    // Boundary codes with all-ones and all-zeros words.
    for (int i = 0; i < 8; i++) d[i] = 32'h0;
    d[7] = 32'hFFFF_FFFF;
    sel = 3'd7;
    check_y("ones_sel7");
    clock_edge("ones_yq");
    sel = 3'd6;
    check_y("zeros_sel6");
    clock_edge("zeros_yq");
    d[0] = 32'hFFFF_FFFF;
    d[7] = 32'h0;
    sel = 3'd0;
    check_y("ones_sel0");

    // Load then hold.
    sel  = 3'd3;
    d[3] = 32'hDEAD_BEEF;
    en   = 1'b1;
    check_y("load_y");
    clock_edge("load_yq");
    d[3] = 32'h1234_5678;
    en   = 1'b0;
    check_y("hold_y");
    clock_edge("hold_yq");
    chk("hold_value", yq, 32'hDEAD_BEEF);

    // Asynchronous reset between edges.
    #2;
    rstn = 1'b0;
    #1;
    exp_yq = 32'h0;
    chk("async_rst_yq", yq, 32'h0);
    check_y("async_rst_y");
    en = 1'b1;
    clock_edge("rst_low_en");
    rstn = 1'b1;
    check_y("post_rst_y");
    clock_edge("post_rst_load");

    // Unselected input toggling leaves Y alone.
    sel  = 3'd2;
    d[2] = 32'hCAFE_F00D;
    for (int k = 0; k < 8; k++) begin
      d[5] = $urandom;
      #1;
      chk($sformatf("unsel_toggle%0d", k), y, 32'hCAFE_F00D);
    end

    // Random traffic.
    for (int c = 0; c < 1000; c++) begin
      sel = 3'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) d[i] = $urandom;
      en = 1'($urandom_range(0, 1));
      check_y("rand_y");
      clock_edge("rand_yq");
    end

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
